abs_phase_sched: RTL
====================

Name: abs_phase_sched

Overview:
Frame-level scheduler for the 3-step absolute-phase unwrapping pipeline. It joins three wrapped-phase AXI-Stream inputs (phase1/2/3, one per fringe frequency) and issues pixel triples to the pipeline in lockstep. It generates per-line tlast and enforces a credit scheme because the pipeline has no backpressure. It tracks pipeline output to declare frame completion and flags line-length errors.

Parameters:
FRAME_W, 1280, pixels per line (>=2)
FRAME_H, 800, lines per frame (>=1)
CREDITS, 32, depth of downstream output FIFO; max pixels in flight plus buffered
CNT_W, 16, width of x/y/line counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start_i  in  1  pulse: begin one frame (honoured in IDLE only)
abort_i  in  1  pulse: abandon frame, return to IDLE
busy_o  out  1  high in RUN or DRAIN
done_o  out  1  one-cycle pulse when frame fully output
err_o  out  1  sticky: line-length or credit-overflow error; cleared by start_i
s_phase1_tdata/s_phase2_tdata/s_phase3_tdata  in  16 each  wrapped phase, signed 2QN
s_phase1_tvalid/s_phase2_tvalid/s_phase3_tvalid  in  1 each  input valid
s_phase1_tready/s_phase2_tready/s_phase3_tready  out  1 each  input ready
p_vld_o  out  1  pipeline issue valid
p_phase1_o/p_phase2_o/p_phase3_o  out  16 each  issued phases
p_tlast_o  out  1  last pixel of line
p_vld_i  in  1  pipeline result valid
p_tlast_i  in  1  pipeline result tlast
credit_ret_i  in  1  pulse: downstream FIFO popped one entry

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; credit=CREDITS; counters 0; err_o=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: all tready=0. start_i -> RUN. Clear x, y, out_lines and out_x; clear err_o. Credit is not reloaded; it persists across frames.
- RUN: fire = s1.tvalid & s2.tvalid & s3.tvalid & (credit>0). All three tready = fire, so all three streams are consumed in the same cycle or none is. tready must not depend on a single tvalid.
- On fire, the next cycle has p_vld_o=1, p_phaseK_o=s_phaseK_tdata, and p_tlast_o=(x==FRAME_W-1). Issue latency is exactly 1 cycle. Without fire, p_vld_o=0 and data holds.
- x increments on fire and wraps to 0 at FRAME_W-1, which increments y. Fire at (x=FRAME_W-1, y=FRAME_H-1) moves to DRAIN.
- Credit update: credit <= credit - fire + credit_ret_i. Simultaneous fire and return leaves credit unchanged. credit_ret_i at credit==CREDITS with no fire: credit holds and err_o is set.
- Output tracking (RUN and DRAIN), on each p_vld_i:
  - out_x increments.
  - If p_tlast_i, out_lines increments and out_x resets to 0.
  - If p_tlast_i with out_x!=FRAME_W-1, or out_x reaching FRAME_W without tlast, set err_o (counters still advance as above).
- DRAIN: tready=0. When out_lines==FRAME_H, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o=0 in DONE.
- abort_i in RUN or DRAIN: next cycle is IDLE, tready=0, p_vld_o=0, no done_o. Credit is kept, since in-flight results still return credits. abort_i has priority over start_i and over fire in the same cycle.
- start_i outside IDLE is ignored.
- Pipeline results arriving in IDLE are ignored for counting, but credit_ret_i is always honoured.
- Widths: x/y/out counters are CNT_W bits; credit is clog2(CREDITS+1) bits.

Test Plan:
- Reset, FRAME_W=4, FRAME_H=2, all inputs always valid, credit_ret_i mirrors p_vld_o 20 cycles later -> 8 issues on consecutive cycles, p_tlast_o on issues 4 and 8, done_o one cycle after the 2nd returned tlast, err_o=0.
- CREDITS=3, no credit_ret_i -> exactly 3 fires, then tready=0; one credit_ret_i pulse -> exactly 1 more fire on the next cycle.
- s_phase2_tvalid low for 5 cycles while others are high -> all three tready=0 in those cycles, no p_vld_o, and data order is preserved afterwards (check by incrementing data patterns).
- Simultaneous fire and credit_ret_i with credit=1 -> credit stays 1 and the next fire is allowed.
- Returned p_tlast_i after 3 pixels with FRAME_W=4 -> err_o=1 and sticky; next start_i clears it.
- abort_i mid-line (x=2) -> IDLE next cycle, busy_o=0, no done_o; a following start_i runs a clean frame with x starting at 0.

Source files
------------

// File: rtl/abs_phase_sched.sv
// Frame scheduler for the 3-step absolute-phase pipeline: joins three phase streams,
// issues lockstep triples under a credit limit, and tracks returned lines to finish a frame.
module abs_phase_sched #(
    parameter int FRAME_W = 1280,
    parameter int FRAME_H = 800,
    parameter int CREDITS = 32,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic [15:0] s_phase1_tdata,
    input  logic [15:0] s_phase2_tdata,
    input  logic [15:0] s_phase3_tdata,
    input  logic        s_phase1_tvalid,
    input  logic        s_phase2_tvalid,
    input  logic        s_phase3_tvalid,
    output logic        s_phase1_tready,
    output logic        s_phase2_tready,
    output logic        s_phase3_tready,
    output logic        p_vld_o,
    output logic [15:0] p_phase1_o,
    output logic [15:0] p_phase2_o,
    output logic [15:0] p_phase3_o,
    output logic        p_tlast_o,
    input  logic        p_vld_i,
    input  logic        p_tlast_i,
    input  logic        credit_ret_i
);
    localparam int CR_W = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(FRAME_H - 1);
    localparam logic [CNT_W-1:0] LINES  = CNT_W'(FRAME_H);
    localparam logic [CR_W-1:0]  CR_MAX = CR_W'(CREDITS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0]  out_x_q, out_x_d, out_lines_q, out_lines_d;
    logic [CR_W-1:0]   credit_q, credit_d;
    logic              err_q, err_d, busy_q, busy_d, done_q, done_d;
    logic              p_vld_q, p_vld_d, p_tlast_q, p_tlast_d;
    logic [15:0]       p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic              fire, tracking;

    // Handshake: all three streams are accepted together (tready = fire) or not at all;
    // fire never depends on a single tvalid, and abort blocks acceptance.
    assign fire = (state_q == RUN) && s_phase1_tvalid && s_phase2_tvalid && s_phase3_tvalid
                  && (credit_q != '0) && !abort_i;
    assign tracking = (state_q == RUN) || (state_q == DRAIN);

    assign s_phase1_tready = fire;
    assign s_phase2_tready = fire;
    assign s_phase3_tready = fire;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign p_vld_o    = p_vld_q;
    assign p_tlast_o  = p_tlast_q;
    assign p_phase1_o = p1_q;
    assign p_phase2_o = p2_q;
    assign p_phase3_o = p3_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        out_x_d     = out_x_q;
        out_lines_d = out_lines_q;
        credit_d    = credit_q;
        err_d       = err_q;
        p_vld_d     = fire;
        p_tlast_d   = p_tlast_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        p3_d        = p3_q;

        if (fire) begin
            p1_d      = s_phase1_tdata;
            p2_d      = s_phase2_tdata;
            p3_d      = s_phase3_tdata;
            p_tlast_d = (x_q == X_LAST);
        end

        if (state_q == IDLE && start_i) begin
            err_d = 1'b0;
        end

        // Credits survive abort and frame boundaries; a return beyond the pool is an error.
        if (fire && !credit_ret_i) begin
            credit_d = credit_q - 1'b1;
        end else if (!fire && credit_ret_i) begin
            if (credit_q == CR_MAX) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end

        if (tracking && p_vld_i) begin
            if (p_tlast_i) begin
                if (out_x_q != X_LAST) begin
                    err_d = 1'b1;
                end
                out_lines_d = out_lines_q + 1'b1;
                out_x_d     = '0;
            end else begin
                if (out_x_q == X_LAST) begin
                    err_d = 1'b1;
                end
                out_x_d = out_x_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = RUN;
                    x_d         = '0;
                    y_d         = '0;
                    out_x_d     = '0;
                    out_lines_d = '0;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (fire) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (out_lines_d == LINES) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            out_x_q     <= '0;
            out_lines_q <= '0;
            credit_q    <= CR_MAX;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            p_vld_q     <= 1'b0;
            p_tlast_q   <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            p3_q        <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            out_x_q     <= out_x_d;
            out_lines_q <= out_lines_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            p_vld_q     <= p_vld_d;
            p_tlast_q   <= p_tlast_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            p3_q        <= p3_d;
        end
    end
endmodule
